// File: rtl/rr_arb_mux_ctrl_pkg.sv
// rr_arb_mux_ctrl_pkg: shared select-width helper and output-stage state encoding
package rr_arb_mux_ctrl_pkg;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating priority encoder, first set request at or after ptr with wrap
module rr_prio_enc
  import rr_arb_mux_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);
  // lowest request below ptr is the fallback; lowest request at or above ptr overrides it
  always_comb begin
    grant = ptr;
    grant_valid = |req;
    for (int i = N - 1; i >= 0; i--) grant = (req[i] && SW'(i) < ptr) ? SW'(i) : grant;
    for (int i = N - 1; i >= 0; i--) grant = (req[i] && SW'(i) >= ptr) ? SW'(i) : grant;
  end
endmodule

// File: rtl/rr_arb_mux_ctrl.sv
// rr_arb_mux_ctrl: round-robin arbiter steering an external mux into a one-entry output register
module rr_arb_mux_ctrl
  import rr_arb_mux_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 16,
  localparam int SW = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_valid,
  output logic [N-1:0]  req_ready,
  output logic [SW-1:0] sel,
  input  logic [M-1:0]  mux_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic [SW-1:0] out_src
);
  logic [0:0] st;
  logic [SW-1:0] ptr, grant;
  logic grant_valid, accept;
  rr_prio_enc #(.N(N)) u_enc (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  assign out_valid = st == ST_FULL;
  assign accept = (!out_valid | out_ready) & grant_valid & !rst;
  assign req_ready = accept ? N'(1) << grant : '0;
  assign sel = grant;
  // load on accept (drain and reload may coincide), otherwise drain or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_EMPTY;
      out_data <= '0;
      out_src <= '0;
      ptr <= '0;
    end else if (accept) begin
      st <= ST_FULL;
      out_data <= mux_data;
      out_src <= grant;
      ptr <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
    end else if (out_valid & out_ready) begin
      st <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_rr_arb_mux_ctrl.sv
// tb_rr_arb_mux_ctrl: directed and random checks of N=4 and N=3 arbiters against a behavioural model
module tb_rr_arb_mux_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] rv4 = '0, rr4;
  logic [2:0] rv3 = '0, rr3;
  logic or4 = 0, or3 = 0, ov4, ov3;
  logic [1:0] sel4, sel3, os4, os3;
  logic [15:0] vin4 [4];
  logic [15:0] vin3 [4];
  logic [15:0] md4, md3, od4, od3, held;
  int n_chk = 0, n_pass = 0, mode = 0;
  int m_ptr [2];
  int m_os [2];
  logic m_ov [2];
  logic [15:0] m_od [2];

  always #5 clk = ~clk;
  assign md4 = vin4[sel4];
  assign md3 = vin3[sel3];

  rr_arb_mux_ctrl #(.N(4), .M(16)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .sel(sel4), .mux_data(md4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_src(os4)
  );
  rr_arb_mux_ctrl #(.N(3), .M(16)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .sel(sel3), .mux_data(md3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_src(os3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int find(input int n, input int p, input logic [3:0] rv);
    int r = -1;
    for (int k = 0; k < n; k++) if (r < 0 && rv[(p + k) % n]) r = (p + k) % n;
    return r;
  endfunction

  task automatic step(input logic r, input logic [3:0] a4, input logic [2:0] a3, input logic o4, input logic o3);
    int g [2];
    bit acc [2];
    int n;
    logic o;
    @(negedge clk);
    rst = r; rv4 = a4; rv3 = a3; or4 = o4; or3 = o3;
    for (int i = 0; i < 4; i++) begin
      vin4[i] = mode == 1 ? 16'hA000 + 16'(i) : mode == 2 ? 16'h1234 : 16'($urandom);
      vin3[i] = mode == 1 ? 16'hA000 + 16'(i) : mode == 2 ? 16'h1234 : 16'($urandom);
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      n = j == 0 ? 4 : 3;
      o = j == 0 ? o4 : o3;
      g[j] = find(n, m_ptr[j], j == 0 ? a4 : {1'b0, a3});
      acc[j] = !r && g[j] >= 0 && (!m_ov[j] || o);
    end
    chk("sel4", 32'(sel4), g[0] >= 0 ? g[0] : m_ptr[0]);
    chk("sel3", 32'(sel3), g[1] >= 0 ? g[1] : m_ptr[1]);
    chk("sel3_range", 32'(sel3 < 2'd3), 1);
    chk("ready4", 32'(rr4), acc[0] ? 1 << g[0] : 0);
    chk("ready3", 32'(rr3), acc[1] ? 1 << g[1] : 0);
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      n = j == 0 ? 4 : 3;
      o = j == 0 ? o4 : o3;
      if (r) begin
        m_ov[j] = 0; m_od[j] = '0; m_os[j] = 0; m_ptr[j] = 0;
      end else if (acc[j]) begin
        m_od[j] = j == 0 ? vin4[g[j]] : vin3[g[j]];
        m_os[j] = g[j]; m_ov[j] = 1; m_ptr[j] = (g[j] + 1) % n;
      end else if (m_ov[j] && o) m_ov[j] = 0;
    end
    #1;
    chk("valid4", 32'(ov4), 32'(m_ov[0]));
    chk("data4", 32'(od4), 32'(m_od[0]));
    chk("src4", 32'(os4), m_os[0]);
    chk("valid3", 32'(ov3), 32'(m_ov[1]));
    chk("data3", 32'(od3), 32'(m_od[1]));
    chk("src3", 32'(os3), m_os[1]);
  endtask

  initial begin
    m_ptr = '{0, 0}; m_os = '{0, 0}; m_ov = '{0, 0}; m_od = '{16'h0, 16'h0};
    for (int i = 0; i < 4; i++) begin vin4[i] = '0; vin3[i] = '0; end
    step(1, 4'b1111, 3'b111, 0, 0);
    step(1, 4'b1111, 3'b111, 0, 0);
    chk("rst_valid", 32'(ov4), 0);
    chk("rst_data", 32'(od4), 0);
    step(0, 4'b0000, 3'b000, 1, 1);
    mode = 1;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b1111, 3'b111, 1, 1);
      chk("rot_data", 32'(od4), 32'h0000A000 + 32'(k % 4));
      chk("rot_src", 32'(os4), k % 4);
    end
    mode = 0;
    step(0, 4'b0100, 3'b000, 1, 1);
    chk("ptr3_setup", 32'(os4), 2);
    step(0, 4'b0101, 3'b000, 1, 1);
    chk("wrap_grant0", 32'(os4), 0);
    step(0, 4'b0101, 3'b000, 1, 1);
    chk("skip_grant2", 32'(os4), 2);
    step(0, 4'b0000, 3'b000, 1, 1);
    step(0, 4'b0010, 3'b000, 1, 1);
    held = od4;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b0010, 3'b000, 0, 1);
      chk("stall_data", 32'(od4), 32'(held));
      chk("stall_valid", 32'(ov4), 1);
    end
    step(0, 4'b0010, 3'b000, 1, 1);
    chk("reload_src", 32'(os4), 1);
    chk("reload_valid", 32'(ov4), 1);
    mode = 2;
    step(0, 4'b1111, 3'b111, 1, 1);
    chk("pre_rst_data", 32'(od4), 32'h1234);
    step(1, 4'b1111, 3'b111, 1, 1);
    chk("midrst_valid", 32'(ov4), 0);
    mode = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0000, 3'b111, 1, 1);
      chk("n3_src", 32'(os3), k % 3);
    end
    repeat (400)
      step($urandom_range(0, 39) == 0, 4'($urandom), 3'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
